// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared encodings for the ROM message sequencer
//
// Purpose : FSM state encoding (3 bits) and end_reason status codes used by
//           rom_msg_sequencer and its benches.
// Contents: seq_state_t  - sequencer FSM states
//           end_reason_t - completion status reported on end_reason
package uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_FETCH     = 3'd1,
      ST_CHECK     = 3'd2,
      ST_WAIT_TX   = 3'd3,
      ST_SEND      = 3'd4,
      ST_WAIT_BUSY = 3'd5,
      ST_NEXT      = 3'd6,
      ST_DONE      = 3'd7
   } seq_state_t;

   typedef enum logic [1:0] {
      ER_NONE  = 2'd0,
      ER_TERM  = 2'd1,
      ER_WRAP  = 2'd2,
      ER_ABORT = 2'd3
   } end_reason_t;

endpackage

// File: rtl/rom_msg_sequencer.sv
// rtl/rom_msg_sequencer.sv - single-shot, abortable ROM-to-UART message player
//
// Purpose : On an accepted go, walks a synchronous ROM from start_addr, stops
//           on the terminator byte, on address wrap-around or on abort, and
//           hands every other byte to uart_tx with a start/ready handshake.
// Ports   : clk, rst_n        - clock, asynchronous active-low reset
//           go, abort         - start request (IDLE only), stop request
//           start_addr        - first ROM address, captured on accepted go
//           rom_addr/rom_data - registered ROM address, ROM read data
//           tx_data/tx_start  - byte and one-cycle start pulse to uart_tx
//           tx_ready          - uart_tx idle indication
//           busy/done         - sequence active, one-cycle completion pulse
//           end_reason        - NONE/TERM/WRAP/ABORT, held until next go
//           sent_count        - bytes started in the current/last sequence
module rom_msg_sequencer
   import uart_pkg::*;
#(
   parameter int                    ADDR_WIDTH = 5,
   parameter int                    DATA_WIDTH = 8,
   parameter logic [DATA_WIDTH-1:0] TERMINATOR = 8'h00
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  go,
   input  logic                  abort,
   input  logic [ADDR_WIDTH-1:0] start_addr,
   output logic [ADDR_WIDTH-1:0] rom_addr,
   input  logic [DATA_WIDTH-1:0] rom_data,
   output logic [DATA_WIDTH-1:0] tx_data,
   output logic                  tx_start,
   input  logic                  tx_ready,
   output logic                  busy,
   output logic                  done,
   output logic [1:0]            end_reason,
   output logic [ADDR_WIDTH:0]   sent_count
);

   localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [ADDR_WIDTH:0]   COUNT_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

   seq_state_t            state;
   logic [ADDR_WIDTH-1:0] start_q;
   logic                  abort_pending;
   logic [ADDR_WIDTH-1:0] addr_inc;

   // Plain binary increment; the natural overflow gives the modulo-2^N wrap.
   always_comb begin
      addr_inc = rom_addr + ADDR_ONE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= ST_IDLE;
         start_q       <= '0;
         abort_pending <= 1'b0;
         rom_addr      <= '0;
         tx_data       <= '0;
         tx_start      <= 1'b0;
         busy          <= 1'b0;
         done          <= 1'b0;
         end_reason    <= ER_NONE;
         sent_count    <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               tx_start <= 1'b0;
               done     <= 1'b0;
               if (go) begin
                  rom_addr      <= start_addr;
                  start_q       <= start_addr;
                  sent_count    <= '0;
                  end_reason    <= ER_NONE;
                  abort_pending <= 1'b0;
                  busy          <= 1'b1;
                  state         <= ST_FETCH;
               end
            end

            // ROM is registering rom_addr this cycle; data is usable in CHECK.
            ST_FETCH: begin
               if (abort) begin
                  end_reason <= ER_ABORT;
                  done       <= 1'b1;
                  state      <= ST_DONE;
               end else begin
                  state <= ST_CHECK;
               end
            end

            // Abort outranks the terminator when both hit this cycle.
            ST_CHECK: begin
               if (abort) begin
                  end_reason <= ER_ABORT;
                  done       <= 1'b1;
                  state      <= ST_DONE;
               end else if (rom_data == TERMINATOR) begin
                  end_reason <= ER_TERM;
                  done       <= 1'b1;
                  state      <= ST_DONE;
               end else begin
                  tx_data <= rom_data;
                  state   <= ST_WAIT_TX;
               end
            end

            // Nothing has been started yet, so abort can still drop the byte.
            ST_WAIT_TX: begin
               if (abort) begin
                  end_reason <= ER_ABORT;
                  done       <= 1'b1;
                  state      <= ST_DONE;
               end else if (tx_ready) begin
                  tx_start   <= 1'b1;
                  sent_count <= sent_count + COUNT_ONE;
                  state      <= ST_SEND;
               end
            end

            ST_SEND: begin
               tx_start <= 1'b0;
               if (abort) begin
                  abort_pending <= 1'b1;
               end
               state <= ST_WAIT_BUSY;
            end

            // Holding here until uart_tx drops ready keeps a stale ready from
            // launching the next byte twice.
            ST_WAIT_BUSY: begin
               if (abort) begin
                  abort_pending <= 1'b1;
               end
               if (!tx_ready) begin
                  state <= ST_NEXT;
               end
            end

            // Byte boundary: a pending (or fresh) abort outranks wrap detection.
            ST_NEXT: begin
               rom_addr <= addr_inc;
               if (abort_pending || abort) begin
                  end_reason <= ER_ABORT;
                  done       <= 1'b1;
                  state      <= ST_DONE;
               end else if (addr_inc == start_q) begin
                  end_reason <= ER_WRAP;
                  done       <= 1'b1;
                  state      <= ST_DONE;
               end else begin
                  state <= ST_FETCH;
               end
            end

            ST_DONE: begin
               done          <= 1'b0;
               busy          <= 1'b0;
               abort_pending <= 1'b0;
               state         <= ST_IDLE;
            end

            default: begin
               tx_start <= 1'b0;
               done     <= 1'b0;
               busy     <= 1'b0;
               state    <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
